writeback_arbiter: RTL and testbench

Write-side front end of the 32x32 register file: merges single-cycle ALU results and variable-latency load responses into the file's single write port (RegWrite/writeReg/writeData). Buffers load responses when the ALU holds the port and keeps a per-register pending-load scoreboard that decode uses for stall decisions. Sits between the execute/memory stages and the register file.

---
 rtl/writeback_arbiter_if.sv | 46 ++++
 rtl/writeback_arbiter.sv | 151 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if
//   Groups the write-side front-end signals of the register file.
//   master : execute/memory side. It drives ALU results, load issue and load
//            responses, and observes ld_ready, the write port and the scoreboard.
//   slave  : the writeback_arbiter itself.
//   Ports (all XLEN-wide data unless noted):
//     alu_valid/alu_rd/alu_data        ALU result, no backpressure
//     ld_issue/ld_issue_rd             load issued, marks destination pending
//     ld_valid/ld_ready/ld_rd/ld_data  load response handshake
//     RegWrite/writeReg/writeData      registered register-file write port
//     pending[31:0]                    per-register outstanding-load scoreboard
interface writeback_arbiter_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            RegWrite;
  logic [4:0]      writeReg;
  logic [XLEN-1:0] writeData;
  logic [31:0]     pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    input  RegWrite, writeReg, writeData,
    input  pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    output RegWrite, writeReg, writeData,
    output pending
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges single-cycle ALU results and variable-latency load responses into
//   the single register-file write port. Load responses are queued in a small
//   FIFO while the ALU owns the port, and a pending-load scoreboard is kept for
//   decode stall decisions.
//   Ports:
//     CLK  rising-edge clock
//     RST  synchronous active-high reset
//     wb   writeback_arbiter_if.slave (ALU, load issue, load response, write
//          port, scoreboard)
//   Parameters: XLEN data width, DEPTH load buffer entries (power of two, >=2).
//   Build option: WB_BYPASS_EN. When it is defined, a load response that arrives
//   with the buffer empty and no ALU result goes straight to the write port
//   and skips the buffer.
module writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic               CLK,
  input logic               RST,
  writeback_arbiter_if.slave wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]      buf_rd_q   [DEPTH];
  logic [4:0]      buf_rd_d   [DEPTH];
  logic [XLEN-1:0] buf_data_q [DEPTH];
  logic [XLEN-1:0] buf_data_d [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic            reg_write_q, reg_write_d;
  logic [4:0]      write_reg_q, write_reg_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [31:0]     pending_q, pending_d;

  logic       empty;
  logic       full;
  logic       ld_ready;
  logic       accept;
  logic       push;
  logic       pop;
  logic       ld_sel;
  logic [4:0] ld_sel_rd;

  // While RST is high, ld_ready is held low. This way a response cannot be
  // accepted into a buffer that is about to be discarded.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    ld_ready = !full && !RST;
    accept   = wb.ld_valid && ld_ready;
  end

  // Output source selection: ALU first, then buffer head, then (optionally) a
  // response arriving this cycle. x0 destinations are consumed but not written.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    push         = accept;
    pop          = 1'b0;
    ld_sel       = 1'b0;
    ld_sel_rd    = '0;

    if (wb.alu_valid) begin
      reg_write_d  = (wb.alu_rd != 5'd0);
      write_reg_d  = wb.alu_rd;
      write_data_d = wb.alu_data;
    end else if (!empty) begin
      pop          = 1'b1;
      ld_sel       = 1'b1;
      ld_sel_rd    = buf_rd_q[rd_ptr_q];
      reg_write_d  = (buf_rd_q[rd_ptr_q] != 5'd0);
      write_reg_d  = buf_rd_q[rd_ptr_q];
      write_data_d = buf_data_q[rd_ptr_q];
    end
`ifdef WB_BYPASS_EN
    else if (accept) begin
      push         = 1'b0;
      ld_sel       = 1'b1;
      ld_sel_rd    = wb.ld_rd;
      reg_write_d  = (wb.ld_rd != 5'd0);
      write_reg_d  = wb.ld_rd;
      write_data_d = wb.ld_data;
    end
`endif
  end

  // Clear is applied before set, so a new issue to the same register wins
  // over the retiring load.
  always_comb begin
    pending_d = pending_q;
    if (ld_sel) begin
      pending_d[ld_sel_rd] = 1'b0;
    end
    if (wb.ld_issue) begin
      pending_d[wb.ld_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    if (push) begin
      buf_rd_d[wr_ptr_q]   = wb.ld_rd;
      buf_data_d[wr_ptr_q] = wb.ld_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  // Buffer storage needs no reset. Validity is tracked entirely by count_q.
  always_ff @(posedge CLK) begin
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
  end

  assign wb.ld_ready  = ld_ready;
  assign wb.RegWrite  = reg_write_q;
  assign wb.writeReg  = write_reg_q;
  assign wb.writeData = write_data_q;
  assign wb.pending   = pending_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Directed steps followed by a random phase. Every cycle is checked against
//   a queue-based reference model of the write-port and scoreboard rules.
module tb_writeback_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic CLK;
  logic RST;

  writeback_arbiter_if #(.XLEN(XLEN)) wb();

  writeback_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .wb  (wb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  ent_t            mq[$];
  logic            m_we;
  logic [4:0]      m_wr;
  logic [XLEN-1:0] m_wd;
  logic [31:0]     m_pend;
  logic            acc_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_idle();
    wb.alu_valid   = 1'b0;
    wb.alu_rd      = '0;
    wb.alu_data    = '0;
    wb.ld_issue    = 1'b0;
    wb.ld_issue_rd = '0;
    wb.ld_valid    = 1'b0;
    wb.ld_rd       = '0;
    wb.ld_data     = '0;
  endtask

  // One clock: check ld_ready mid-cycle, step the model at the edge, then
  // check the registered outputs.
  task automatic cycle();
    logic m_ready;
    logic acc;
    ent_t e;
    @(negedge CLK);
    m_ready = !RST && (mq.size() < DEPTH);
    chk("ld_ready", wb.ld_ready, m_ready);
    acc_seen = wb.ld_valid && wb.ld_ready;
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      m_we = 0; m_wr = 0; m_wd = 0; m_pend = 0;
    end else begin
      acc = wb.ld_valid && (mq.size() < DEPTH);
      if (wb.alu_valid) begin
        m_we = (wb.alu_rd != 0); m_wr = wb.alu_rd; m_wd = wb.alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = (e.rd != 0); m_wr = e.rd; m_wd = e.data;
        m_pend[e.rd] = 1'b0;
      end
`ifdef WB_BYPASS_EN
      else if (acc) begin
        m_we = (wb.ld_rd != 0); m_wr = wb.ld_rd; m_wd = wb.ld_data;
        m_pend[wb.ld_rd] = 1'b0;
        acc = 1'b0;
      end
`endif
      else begin
        m_we = 1'b0;
      end
      if (acc) begin
        e.rd = wb.ld_rd; e.data = wb.ld_data;
        mq.push_back(e);
      end
      if (wb.ld_issue) m_pend[wb.ld_issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
    #1;
    chk("RegWrite", wb.RegWrite, m_we);
    if (m_we) begin
      chk("writeReg", wb.writeReg, m_wr);
      chk("writeData", wb.writeData, m_wd);
    end
    chk("pending", wb.pending, m_pend);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int got[3];
    int nw;
    m_we = 0; m_wr = 0; m_wd = 0; m_pend = 0; acc_seen = 0;
    set_idle();
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Reset held two cycles, then idle.
    cycle();
    cycle();
    chk("rst_we", wb.RegWrite, 0);
    chk("rst_wreg", wb.writeReg, 0);
    chk("rst_wdata", wb.writeData, 0);
    chk("rst_pend", wb.pending, 0);
    RST = 1'b0;
    cycle();
    chk("ready_after_rst", acc_seen || wb.ld_ready, 1);

    // ALU write, then ALU write to x0.
    wb.alu_valid = 1; wb.alu_rd = 5; wb.alu_data = 32'hDEADBEEF;
    cycle();
    chk("alu_we", wb.RegWrite, 1);
    chk("alu_wreg", wb.writeReg, 5);
    chk("alu_wdata", wb.writeData, 32'hDEADBEEF);
    wb.alu_rd = 0; wb.alu_data = 32'h1234;
    cycle();
    chk("alu_x0_we", wb.RegWrite, 0);
    set_idle();
    cycle();

    // Scoreboard: issue x7, then its response.
    wb.ld_issue = 1; wb.ld_issue_rd = 7;
    cycle();
    chk("sb_set", wb.pending, 32'h80);
    set_idle();
    wb.ld_valid = 1; wb.ld_rd = 7; wb.ld_data = 32'h12;
    cycle();
    set_idle();
`ifdef WB_BYPASS_EN
    chk("sb_byp_we", wb.RegWrite, 1);
    chk("sb_byp_pend", wb.pending, 0);
    cycle();
`else
    chk("sb_buf_we", wb.RegWrite, 0);
    chk("sb_buf_pend", wb.pending, 32'h80);
    cycle();
    chk("sb_we", wb.RegWrite, 1);
    chk("sb_wreg", wb.writeReg, 7);
    chk("sb_wdata", wb.writeData, 32'h12);
    chk("sb_clear", wb.pending, 0);
`endif

    // Contention: ALU busy 4 cycles while responses x3, x4, x5 arrive.
    wb.alu_valid = 1; wb.alu_rd = 10; wb.alu_data = 1;
    wb.ld_valid = 1; wb.ld_rd = 3; wb.ld_data = 32'h33;
    cycle();
    wb.alu_rd = 11; wb.ld_rd = 4; wb.ld_data = 32'h44;
    cycle();
    wb.alu_rd = 12; wb.ld_rd = 5; wb.ld_data = 32'h55;
    cycle();
    chk("third_resp_stalled", acc_seen, 0);
    wb.alu_rd = 13;
    cycle();
    chk("full_under_alu", acc_seen, 0);
    wb.alu_valid = 0;
    nw = 0;
    for (int i = 0; i < 12 && nw < 3; i++) begin
      cycle();
      if (acc_seen) wb.ld_valid = 0;
      if (wb.RegWrite) begin
        got[nw] = int'(wb.writeReg);
        nw++;
      end
    end
    chk("drain_count", nw, 3);
    chk("drain_0", got[0], 3);
    chk("drain_1", got[1], 4);
    chk("drain_2", got[2], 5);
    set_idle();
    cycle();

    // Same-edge set and clear of pending[9].
    wb.ld_issue = 1; wb.ld_issue_rd = 9;
    cycle();
    set_idle();
    wb.ld_valid = 1; wb.ld_rd = 9; wb.ld_data = 32'h99;
`ifdef WB_BYPASS_EN
    wb.ld_issue = 1; wb.ld_issue_rd = 9;
    cycle();
    set_idle();
`else
    cycle();
    set_idle();
    wb.ld_issue = 1; wb.ld_issue_rd = 9;
    cycle();
    set_idle();
`endif
    chk("same_edge_we", wb.RegWrite, 1);
    chk("same_edge_wreg", wb.writeReg, 9);
    chk("same_edge_pend9", wb.pending[9], 1);
    wb.ld_valid = 1; wb.ld_rd = 9; wb.ld_data = 32'h9A;
    cycle();
    set_idle();
    cycle();
    cycle();
    chk("x9_retired", wb.pending, 0);

    // Reset mid-operation with two responses buffered.
    wb.alu_valid = 1; wb.alu_rd = 1; wb.alu_data = 32'hAA;
    wb.ld_valid = 1; wb.ld_rd = 20; wb.ld_data = 32'h20;
    wb.ld_issue = 1; wb.ld_issue_rd = 21;
    cycle();
    wb.ld_issue = 0; wb.ld_rd = 22; wb.ld_data = 32'h22;
    cycle();
    set_idle();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_no_write", wb.RegWrite, 0);
      chk("post_rst_pend", wb.pending, 0);
    end

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      wb.alu_valid   = ($urandom_range(0, 99) < 40);
      wb.alu_rd      = 5'($urandom_range(0, 31));
      wb.alu_data    = $urandom;
      wb.ld_valid    = ($urandom_range(0, 99) < 50);
      wb.ld_rd       = 5'($urandom_range(0, 31));
      wb.ld_data     = $urandom;
      wb.ld_issue    = ($urandom_range(0, 99) < 30);
      wb.ld_issue_rd = 5'($urandom_range(0, 31));
      RST            = ($urandom_range(0, 199) == 0);
      cycle();
    end
    set_idle();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
